// File: rtl/mbt_pkg.sv
// Shared widths and types for the dual-lane MBitTree classification pipeline.
package mbt_pkg;

  localparam int PACKET_WIDTH = 104;
  localparam int NODE_WIDTH   = 40;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_PAUSED = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [NODE_WIDTH-1:0] node;
    logic                  matched;
    logic                  lane;
  } result_t;

endpackage

// File: rtl/lane_result_fifo.sv
// Register FIFO for merged lane results: two writes (port 0 lands first) and one read per cycle.
module lane_result_fifo
  import mbt_pkg::*;
#(
  parameter int  FIFO_DEPTH = 8,
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          RSTn,
  input  logic          wr0_en,
  input  result_t       wr0_data,
  input  logic          wr1_en,
  input  result_t       wr1_data,
  input  logic          rd_en,
  output result_t       rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  result_t       mem_reg [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW:0]   avail;
  logic          do_rd;
  logic          ok0;
  logic          ok1;

  assign count   = count_reg;
  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(FIFO_DEPTH));
  assign rd_data = mem_reg[rd_ptr_reg];
  assign do_rd   = rd_en & ~empty;

  // A slot freed by this cycle's read is usable by this cycle's writes.
  always_comb begin
    avail = (CW+1)'(FIFO_DEPTH) - {1'b0, count_reg} + {{CW{1'b0}}, do_rd};
    ok0   = wr0_en & (avail != '0);
    ok1   = wr1_en & (avail > {{CW{1'b0}}, ok0});
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_reg[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (ok0) mem_reg[wr_ptr_reg] <= wr0_data;
      if (ok1) mem_reg[wr_ptr_reg + AW'(ok0)] <= wr1_data;
      wr_ptr_reg <= wr_ptr_reg + AW'(ok0) + AW'(ok1);
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(ok0) + CW'(ok1) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/pkt_lane_scheduler.sv
// Credit-based admission of headers into two tree lanes and in-order merge of their results.
// Also implements the pause/drain handshake used around rule-table updates.
module pkt_lane_scheduler #(
  parameter int                    PACKET_WIDTH = mbt_pkg::PACKET_WIDTH,
  parameter int                    NODE_WIDTH   = mbt_pkg::NODE_WIDTH,
  parameter logic [NODE_WIDTH-1:0] ROOT_NODE    = '0,
  parameter int                    FIFO_DEPTH   = 8
) (
  input  logic                    clk,
  input  logic                    RSTn,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [PACKET_WIDTH-1:0] s_packet,
  input  logic [1:0]              lane_en,
  output logic [PACKET_WIDTH-1:0] lane_packet1,
  output logic [PACKET_WIDTH-1:0] lane_packet2,
  output logic                    lane_valid1,
  output logic                    lane_valid2,
  output logic [NODE_WIDTH-1:0]   lane_node1,
  output logic [NODE_WIDTH-1:0]   lane_node2,
  output logic                    lane_matched1,
  output logic                    lane_matched2,
  input  logic                    r_valid1,
  input  logic                    r_valid2,
  input  logic [NODE_WIDTH-1:0]   r_node1,
  input  logic [NODE_WIDTH-1:0]   r_node2,
  input  logic                    r_matched1,
  input  logic                    r_matched2,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [NODE_WIDTH-1:0]   m_node,
  output logic                    m_matched,
  output logic                    m_lane,
  input  logic                    pause_req,
  output logic                    paused,
  output logic                    err_overflow
);

  import mbt_pkg::sched_state_t;
  import mbt_pkg::result_t;
  import mbt_pkg::ST_RUN;
  import mbt_pkg::ST_DRAIN;
  import mbt_pkg::ST_PAUSED;

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  sched_state_t  state_reg, state_next;
  logic [CW-1:0] used_reg;
  logic          rr_reg;
  logic          err_reg;
  logic          accept;
  logic          pop;
  logic          sel;
  logic          drop;
  logic [1:0]    issue;
  result_t       res1, res2, head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  assign s_ready = (state_reg == ST_RUN) & ~pause_req & (used_reg < CW'(FIFO_DEPTH)) & (|lane_en);
  assign accept  = s_valid & s_ready;
  assign m_valid = ~fifo_empty;
  assign pop     = m_valid & m_ready;
  assign sel     = lane_en[rr_reg] ? rr_reg : ~rr_reg;
  assign issue   = {accept & sel, accept & ~sel};
  assign paused  = (state_reg == ST_PAUSED);
  assign err_overflow = err_reg;

  // Mirrors the FIFO's write gating so a dropped result is flagged.
  assign drop = ((r_valid1 | r_valid2) & fifo_full & ~pop)
              | ((r_valid1 & r_valid2) & (fifo_full | ((fifo_count == CW'(FIFO_DEPTH - 1)) & ~pop)));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:    if (pause_req) state_next = ST_DRAIN;
      ST_DRAIN:  if (!pause_req) state_next = ST_RUN;
                 else if (used_reg == '0) state_next = ST_PAUSED;
      ST_PAUSED: if (!pause_req) state_next = ST_RUN;
      default:   state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_reg <= ST_RUN;
      used_reg  <= '0;
      rr_reg    <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept && !pop) used_reg <= used_reg + CW'(1);
      else if (pop && !accept) used_reg <= used_reg - CW'(1);
      if (accept) rr_reg <= ~sel;
      if (drop) err_reg <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [PACKET_WIDTH-1:0] packet_reg;
    logic [NODE_WIDTH-1:0]   node_reg;
    logic                    valid_reg;
    logic                    matched_reg;

    always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
        packet_reg  <= '0;
        node_reg    <= '0;
        valid_reg   <= 1'b0;
        matched_reg <= 1'b0;
      end else begin
        valid_reg <= issue[gi];
        if (issue[gi]) begin
          packet_reg  <= s_packet;
          node_reg    <= ROOT_NODE;
          matched_reg <= 1'b0;
        end
      end
    end
  end

  assign lane_packet1  = g_lane[0].packet_reg;
  assign lane_node1    = g_lane[0].node_reg;
  assign lane_valid1   = g_lane[0].valid_reg;
  assign lane_matched1 = g_lane[0].matched_reg;
  assign lane_packet2  = g_lane[1].packet_reg;
  assign lane_node2    = g_lane[1].node_reg;
  assign lane_valid2   = g_lane[1].valid_reg;
  assign lane_matched2 = g_lane[1].matched_reg;

  assign res1 = '{node: r_node1, matched: r_matched1, lane: 1'b0};
  assign res2 = '{node: r_node2, matched: r_matched2, lane: 1'b1};

  lane_result_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .RSTn    (RSTn),
    .wr0_en  (r_valid1),
    .wr0_data(res1),
    .wr1_en  (r_valid2),
    .wr1_data(res2),
    .rd_en   (m_ready),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_node    = head.node;
  assign m_matched = head.matched;
  assign m_lane    = head.lane;

endmodule

// File: tb/tb_pkt_lane_scheduler.sv
// Directed bench for pkt_lane_scheduler: the bench plays parser, tree lanes and result consumer.
module tb_pkt_lane_scheduler;

  localparam int PW    = 104;
  localparam int NW    = 40;
  localparam int DEPTH = 8;
  localparam logic [NW-1:0] ROOT = 40'h00_1234_5678;

  logic          clk = 1'b0;
  logic          RSTn = 1'b0;
  logic          s_valid, s_ready;
  logic [PW-1:0] s_packet;
  logic [1:0]    lane_en;
  logic [PW-1:0] lane_packet1, lane_packet2;
  logic          lane_valid1, lane_valid2;
  logic [NW-1:0] lane_node1, lane_node2;
  logic          lane_matched1, lane_matched2;
  logic          r_valid1, r_valid2;
  logic [NW-1:0] r_node1, r_node2;
  logic          r_matched1, r_matched2;
  logic          m_valid, m_ready;
  logic [NW-1:0] m_node;
  logic          m_matched, m_lane;
  logic          pause_req, paused, err_overflow;

  int n_checks;
  int n_fail;
  int cnt;

  always #5 clk = ~clk;

  pkt_lane_scheduler #(
    .PACKET_WIDTH(PW),
    .NODE_WIDTH  (NW),
    .ROOT_NODE   (ROOT),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .RSTn         (RSTn),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_packet     (s_packet),
    .lane_en      (lane_en),
    .lane_packet1 (lane_packet1),
    .lane_packet2 (lane_packet2),
    .lane_valid1  (lane_valid1),
    .lane_valid2  (lane_valid2),
    .lane_node1   (lane_node1),
    .lane_node2   (lane_node2),
    .lane_matched1(lane_matched1),
    .lane_matched2(lane_matched2),
    .r_valid1     (r_valid1),
    .r_valid2     (r_valid2),
    .r_node1      (r_node1),
    .r_node2      (r_node2),
    .r_matched1   (r_matched1),
    .r_matched2   (r_matched2),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_node       (m_node),
    .m_matched    (m_matched),
    .m_lane       (m_lane),
    .pause_req    (pause_req),
    .paused       (paused),
    .err_overflow (err_overflow)
  );

  function automatic logic [PW-1:0] pk(input int i);
    return {8'(i), 96'h0123_4567_89AB_CDEF_0011_2233};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    s_valid = 1'b0; s_packet = '0; lane_en = 2'b11;
    r_valid1 = 1'b0; r_valid2 = 1'b0; r_node1 = '0; r_node2 = '0;
    r_matched1 = 1'b0; r_matched2 = 1'b0;
    m_ready = 1'b0; pause_req = 1'b0; RSTn = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_lane_valid1", lane_valid1, 1'b0);
    chk("rst_lane_valid2", lane_valid2, 1'b0);
    chk("rst_lane_packet1", lane_packet1, '0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_node", m_node, 40'h0);
    chk("rst_paused", paused, 1'b0);
    chk("rst_err", err_overflow, 1'b0);
    chk("rst_s_ready", s_ready, 1'b1);
    RSTn = 1'b1;
    step();
    $display("reset checks done");

    // Round-robin issue
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_packet = pk(i);
      step();
      chk("rr_valid1", lane_valid1, (i % 2 == 0));
      chk("rr_valid2", lane_valid2, (i % 2 == 1));
      if (i % 2 == 0) begin
        chk("rr_packet1", lane_packet1, pk(i));
        chk("rr_node1", lane_node1, ROOT);
        chk("rr_matched1", lane_matched1, 1'b0);
      end else begin
        chk("rr_packet2", lane_packet2, pk(i));
        chk("rr_node2", lane_node2, ROOT);
        chk("rr_matched2", lane_matched2, 1'b0);
      end
      $display("issue %0d: lane_valid1=%0b lane_valid2=%0b", i, lane_valid1, lane_valid2);
    end
    s_valid = 1'b0;
    step();
    chk("idle_valid1", lane_valid1, 1'b0);
    chk("idle_valid2", lane_valid2, 1'b0);
    chk("hold_packet1", lane_packet1, pk(2));

    // Results come back in issue order and merge as lanes 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        r_valid1 = 1'b1; r_node1 = 40'(16 + i); r_matched1 = (i == 2);
      end else begin
        r_valid2 = 1'b1; r_node2 = 40'(16 + i); r_matched2 = (i == 1);
      end
      step();
      r_valid1 = 1'b0;
      r_valid2 = 1'b0;
      if (i == 0) chk("r_to_m_latency", m_valid, 1'b1);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("merge_valid", m_valid, 1'b1);
      chk("merge_node", m_node, 40'(16 + i));
      chk("merge_lane", m_lane, (i % 2 == 1));
      chk("merge_matched", m_matched, ((i == 1) || (i == 2)));
      $display("pop %0d: m_node=%0h m_lane=%0b m_matched=%0b", i, m_node, m_lane, m_matched);
      step();
    end
    m_ready = 1'b0;
    chk("merge_empty", m_valid, 1'b0);

    // Credit backpressure
    s_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (s_ready) cnt++;
      s_packet = pk(i + 8);
      step();
    end
    $display("credit fill: %0d accepts", cnt);
    chk("credit_accepts", cnt, 8);
    chk("credit_block", s_ready, 1'b0);

    // Simultaneous results: lane 1 is the older slot
    r_valid1 = 1'b1; r_node1 = 40'h5; r_matched1 = 1'b1;
    r_valid2 = 1'b1; r_node2 = 40'h9; r_matched2 = 1'b0;
    step();
    r_valid1 = 1'b0;
    r_valid2 = 1'b0;
    chk("simul_valid", m_valid, 1'b1);
    chk("simul_node0", m_node, 40'h5);
    chk("simul_lane0", m_lane, 1'b0);
    chk("simul_matched0", m_matched, 1'b1);
    chk("simul_still_blocked", s_ready, 1'b0);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("pop_frees_credit", s_ready, 1'b1);
    chk("simul_node1", m_node, 40'h9);
    chk("simul_lane1", m_lane, 1'b1);
    chk("simul_no_err", err_overflow, 1'b0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (s_ready) cnt++;
      step();
    end
    $display("after one pop: %0d accepts", cnt);
    chk("one_more_accept", cnt, 1);
    s_valid = 1'b0;

    // Overflow: fill the buffer, then push a ninth result
    for (int i = 0; i < 7; i++) begin
      r_valid1 = 1'b1;
      r_node1  = 40'(256 + i);
      step();
    end
    r_valid1 = 1'b0;
    chk("full_no_err", err_overflow, 1'b0);
    r_valid2 = 1'b1;
    r_node2  = 40'hBAD;
    step();
    r_valid2 = 1'b0;
    chk("ovf_set", err_overflow, 1'b1);
    step();
    step();
    chk("ovf_sticky", err_overflow, 1'b1);
    chk("ovf_head_kept", m_node, 40'h9);
    $display("overflow: err_overflow=%0b head=%0h", err_overflow, m_node);

    // Reset mid-stream
    #2 RSTn = 1'b0;
    #1;
    chk("mid_rst_m_valid", m_valid, 1'b0);
    chk("mid_rst_err", err_overflow, 1'b0);
    chk("mid_rst_m_node", m_node, 40'h0);
    chk("mid_rst_lane_packet1", lane_packet1, '0);
    chk("mid_rst_lane_node2", lane_node2, 40'h0);
    chk("mid_rst_used", s_ready, 1'b1);
    step();
    RSTn = 1'b1;
    $display("mid-stream reset released");

    // Lane disable
    lane_en = 2'b10;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_packet = pk(i + 32);
      step();
      chk("dis_valid2", lane_valid2, 1'b1);
      chk("dis_valid1", lane_valid1, 1'b0);
      chk("dis_packet2", lane_packet2, pk(i + 32));
      $display("lane2-only issue %0d: lane_valid2=%0b", i, lane_valid2);
    end
    s_valid = 1'b0;
    lane_en = 2'b00;
    #1;
    chk("no_lanes_block", s_ready, 1'b0);
    lane_en = 2'b11;
    step();

    // Pause / drain with three in flight
    s_valid   = 1'b1;
    pause_req = 1'b1;
    #1;
    chk("pause_blocks_now", s_ready, 1'b0);
    step();
    chk("pause_no_issue", lane_valid1 | lane_valid2, 1'b0);
    chk("drain_not_paused", paused, 1'b0);
    for (int i = 0; i < 3; i++) begin
      r_valid2 = 1'b1;
      r_node2  = 40'(48 + i);
      step();
    end
    r_valid2 = 1'b0;
    m_ready  = 1'b1;
    for (int i = 0; i < 3; i++) step();
    m_ready = 1'b0;
    chk("drain_last_pop", paused, 1'b0);
    step();
    chk("paused_set", paused, 1'b1);
    chk("paused_blocks", s_ready, 1'b0);
    pause_req = 1'b0;
    s_valid   = 1'b0;
    #1;
    chk("paused_until_edge", s_ready, 1'b0);
    step();
    chk("resume_paused", paused, 1'b0);
    chk("resume_ready", s_ready, 1'b1);
    $display("resume: paused=%0b s_ready=%0b", paused, s_ready);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
